// File: rtl/cms_pix_28_dut_cfg_emu_pkg.sv
// rtl/cms_pix_28_dut_cfg_emu_pkg.sv - shared constants, edge type and edge helper for the config emulator
package cms_pix_28_dut_emu_pkg;

  localparam int CFG_WIDTH_DEF = 256;
  localparam int CNT_W_DEF     = 16;

  typedef enum logic {
    EDGE_RISE = 1'b0,
    EDGE_FALL = 1'b1
  } edge_t;

  function automatic logic edge_hit(input edge_t kind, input logic prev, input logic cur);
    return (kind == EDGE_RISE) ? (cur & ~prev) : (prev & ~cur);
  endfunction

endpackage

// File: rtl/cms_pix_28_dut_cfg_emu_if.sv
// rtl/cms_pix_28_dut_cfg_emu_if.sv - DUT-side static-configuration pins between FW IP and emulator
interface cms_pix_28_dut_cfg_emu_if;

  logic fw_config_clk;
  logic fw_reset_not;
  logic fw_config_in;
  logic fw_config_load;
  logic fw_config_out;

  modport master (
    output fw_config_clk, fw_reset_not, fw_config_in, fw_config_load,
    input  fw_config_out
  );

  modport slave (
    input  fw_config_clk, fw_reset_not, fw_config_in, fw_config_load,
    output fw_config_out
  );

endinterface

// File: rtl/cms_pix_28_dut_cfg_emu_sync_edge.sv
// rtl/cms_pix_28_dut_cfg_emu_sync_edge.sv - multi-flop synchronizer with rise/fall detection on the last stage
module cms_pix_28_sync_edge
  import cms_pix_28_dut_emu_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dly_q, dly_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
    dly_d  = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = edge_hit(EDGE_RISE, dly_q, level);
  assign fall  = edge_hit(EDGE_FALL, dly_q, level);

endmodule

// File: rtl/cms_pix_28_dut_cfg_emu.sv
// rtl/cms_pix_28_dut_cfg_emu.sv - fw_clk-domain emulator of the CMS pixel 28 DUT config shift chain
// Optional config_clk half-period check: CMS_PIX_28_DUT_CFG_EMU_CLK_CHECK_EN
module cms_pix_28_dut_cfg_emu
  import cms_pix_28_dut_emu_pkg::*;
#(
  parameter int CFG_WIDTH       = CFG_WIDTH_DEF,
  parameter int CNT_W           = CNT_W_DEF,
  parameter int SYNC_STAGES     = 2,
  parameter int MIN_HALF_PERIOD = 4
) (
  input  logic                   fw_clk,
  input  logic                   fw_rst_n,
  cms_pix_28_dut_cfg_emu_if.slave cfg,
  output logic [CFG_WIDTH-1:0]   cfg_shadow,
  output logic                   cfg_load_pulse,
  output logic [CNT_W-1:0]       shift_cnt,
  output logic                   clk_violation
);

  logic clk_lvl, clk_rise, clk_fall;
  logic in_lvl, in_rise, in_fall;
  logic load_lvl, load_rise, load_fall;
  logic rst_lvl, rst_rise, rst_fall;

  cms_pix_28_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
    .clk(fw_clk), .rst_n(fw_rst_n), .d(cfg.fw_config_clk),
    .level(clk_lvl), .rise(clk_rise), .fall(clk_fall)
  );
  cms_pix_28_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_in (
    .clk(fw_clk), .rst_n(fw_rst_n), .d(cfg.fw_config_in),
    .level(in_lvl), .rise(in_rise), .fall(in_fall)
  );
  cms_pix_28_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_load (
    .clk(fw_clk), .rst_n(fw_rst_n), .d(cfg.fw_config_load),
    .level(load_lvl), .rise(load_rise), .fall(load_fall)
  );
  cms_pix_28_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rst (
    .clk(fw_clk), .rst_n(fw_rst_n), .d(cfg.fw_reset_not),
    .level(rst_lvl), .rise(rst_rise), .fall(rst_fall)
  );

  logic unused_sigs;
  assign unused_sigs = ^{clk_lvl, in_rise, in_fall, load_lvl, load_fall, rst_rise, rst_fall};

  logic [CFG_WIDTH-1:0] sr_q, sr_d, shadow_q, shadow_d;
  logic                 out_q, out_d;
  logic                 pulse_q, pulse_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  always_comb begin
    sr_d     = sr_q;
    shadow_d = shadow_q;
    out_d    = out_q;
    cnt_d    = cnt_q;
    pulse_d  = 1'b0;
    if (!rst_lvl) begin
      sr_d     = '0;
      shadow_d = '0;
      out_d    = 1'b0;
      cnt_d    = '0;
    end else begin
      if (clk_rise) begin
        sr_d = {sr_q[CFG_WIDTH-2:0], in_lvl};
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      end
      // DUT launches on the falling edge; FW samples on the following rise
      if (clk_fall) out_d = sr_q[CFG_WIDTH-1];
      // Load sees sr_d so a coincident shift lands in the shadow
      if (load_rise) begin
        shadow_d = sr_d;
        pulse_d  = 1'b1;
        cnt_d    = '0;
      end
    end
  end

  always_ff @(posedge fw_clk or negedge fw_rst_n) begin
    if (!fw_rst_n) begin
      sr_q     <= '0;
      shadow_q <= '0;
      out_q    <= 1'b0;
      pulse_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sr_q     <= sr_d;
      shadow_q <= shadow_d;
      out_q    <= out_d;
      pulse_q  <= pulse_d;
      cnt_q    <= cnt_d;
    end
  end

  assign cfg.fw_config_out = out_q;
  assign cfg_shadow        = shadow_q;
  assign cfg_load_pulse    = pulse_q;
  assign shift_cnt         = cnt_q;

`ifdef CMS_PIX_28_DUT_CFG_EMU_CLK_CHECK_EN
  localparam int WID_W = $clog2(MIN_HALF_PERIOD + 1);

  logic [WID_W-1:0] wid_q, wid_d;
  logic             viol_q, viol_d;

  // wid_q holds the length of the half-period that ends on the current edge
  always_comb begin
    wid_d  = wid_q;
    viol_d = viol_q;
    if (clk_rise || clk_fall) begin
      wid_d = WID_W'(1);
      if (wid_q < WID_W'(MIN_HALF_PERIOD)) viol_d = 1'b1;
    end else if (wid_q != WID_W'(MIN_HALF_PERIOD)) begin
      wid_d = wid_q + WID_W'(1);
    end
  end

  always_ff @(posedge fw_clk or negedge fw_rst_n) begin
    if (!fw_rst_n) begin
      wid_q  <= '0;
      viol_q <= 1'b0;
    end else begin
      wid_q  <= wid_d;
      viol_q <= viol_d;
    end
  end

  assign clk_violation = viol_q;
`else
  logic [31:0] unused_min_half;
  assign unused_min_half = MIN_HALF_PERIOD;
  assign clk_violation   = 1'b0;
`endif

endmodule

// File: doc/cms_pix_28_dut_cfg_emu.md
Name: cms_pix_28_dut_cfg_emu

Overview:
- Firmware emulator of the CMS pixel 28 DUT static-configuration chain.
- It is the responder on the far end of the config_clk/config_in/config_load/config_out interface that the FW IP drives.
- Runs on fw_clk. It oversamples the DUT-side pins, shifts config_in into a CFG_WIDTH chain, latches a shadow register on config_load, and returns config_out.
- Used for FW loopback bring-up and regression without silicon.

Parameters:
- CFG_WIDTH, 256, length of the config shift chain in bits (>=2).
- CNT_W, 16, width of the shift counter.
- SYNC_STAGES, 2, synchronizer depth on the asynchronous DUT-side inputs (>=2).
- MIN_HALF_PERIOD, 4, minimum legal config_clk high/low width in fw_clk cycles (used only with the optional feature).

Ports:
- fw_clk  in  1  FW clock; all logic is on its rising edge.
- fw_rst_n  in  1  asynchronous active-low reset.
- fw_config_clk  in  1  DUT config clock, asynchronous to fw_clk.
- fw_reset_not  in  1  DUT reset, active low, asynchronous to fw_clk.
- fw_config_in  in  1  serial config data from FW.
- fw_config_load  in  1  load strobe from FW.
- fw_config_out  out  1  serial chain output to FW.
- cfg_shadow  out  CFG_WIDTH  latched configuration word.
- cfg_load_pulse  out  1  one-cycle pulse when cfg_shadow updates.
- shift_cnt  out  CNT_W  config_clk rising edges since last load or reset; saturating.
- clk_violation  out  1  sticky config_clk width violation flag.

Behaviour:
- Reset: fw_rst_n is asynchronous active-low. While low, all outputs and internal state are 0: shift reg, cfg_shadow, fw_config_out, cfg_load_pulse, shift_cnt, clk_violation, and the synchronizers.
- Synchronization: fw_config_clk, fw_config_in, fw_config_load and fw_reset_not each pass through SYNC_STAGES flops. Edge detection compares the last sync stage with one extra delay flop.
- Shift: on a detected rising edge of config_clk, sr <= {sr[CFG_WIDTH-2:0], cfg_in_s}. The config_in value is the one sampled at that same edge detection, so FW must hold config_in stable for at least SYNC_STAGES+1 fw_clk cycles around the rising edge.
- Shift latency: pin rising edge to sr update is SYNC_STAGES+1 fw_clk cycles.
- Output: fw_config_out is registered and updated on the detected falling edge of config_clk with sr[CFG_WIDTH-1]. This models a DUT that launches on the falling edge, so FW samples on the next rising edge.
- Shift counter: shift_cnt increments on each rising edge and saturates at 2^CNT_W-1 with no wrap.
- Load: on a detected rising edge of config_load:
  - cfg_shadow <= sr;
  - cfg_load_pulse = 1 for exactly one cycle;
  - shift_cnt <= 0.
  - sr is not cleared. A level held high does not re-trigger.
- Simultaneous events: if a config_clk rising edge and a config_load rising edge are detected in the same cycle, the shift occurs first and cfg_shadow captures the post-shift value. shift_cnt ends at 0.
- DUT reset: while the synchronized reset_not is low, sr, cfg_shadow, fw_config_out and shift_cnt are held at 0. Edges are ignored and no cfg_load_pulse is generated. clk_violation is unaffected.
- Reset mid-operation: fw_rst_n low at any time aborts immediately to reset values. No partial-shift state survives.
- States: none beyond the shift datapath; the block is edge-driven with no FSM.

Optional Feature:
- Macro: CMS_PIX_28_DUT_CFG_EMU_CLK_CHECK_EN.
- Defined: a width counter counts consecutive fw_clk cycles of constant synchronized config_clk level. At each detected edge, if the completed half-period was < MIN_HALF_PERIOD, clk_violation sets and stays 1 until fw_rst_n. The shift still occurs.
- Undefined: no counter logic is instantiated and clk_violation is tied to 0.

Decomposition:
- Package cms_pix_28_dut_emu_pkg holds:
  - default constants CFG_WIDTH_DEF=256 and CNT_W_DEF=16;
  - typedef edge_t (rise, fall).
- One natural sub-module, cms_pix_28_sync_edge: a SYNC_STAGES synchronizer plus edge detector, outputting level/rise/fall. Instantiated four times.

Test Plan:
- Reset: hold fw_rst_n=0 with config_clk toggling -> all outputs 0, shift_cnt stays 0.
- Basic load: with CFG_WIDTH=256, shift 256 bits of pattern 0xA5 repeated (MSB first, 8 fw_clk per half-period), then pulse config_load.
  - cfg_shadow equals the pattern;
  - cfg_load_pulse is high exactly 1 cycle;
  - shift_cnt is 256 before the load and 0 after.
- Readback: shift 256 more bits of 0x00 -> fw_config_out replays the previous 0xA5 stream bit by bit. The first bit appears after the first falling edge.
- Simultaneous: align the config_load and 257th config_clk rising edges to the same fw_clk cycle -> cfg_shadow reflects the 257-shift value and shift_cnt=0.
- DUT reset: drive fw_reset_not=0 mid-stream after 100 shifts -> sr/cfg_shadow/shift_cnt are 0, and a load during reset gives no pulse. After release, a fresh 256-bit shift loads correctly.
- Optional (macro defined): use a 2-cycle config_clk high phase with MIN_HALF_PERIOD=4 -> clk_violation=1 and it stays set. Without the macro, clk_violation stays 0.
